sram_like_resp: RTL and testbench

- Responder (slave) end of the CPU's sram-like data-memory handshake (req/addr_ok/data_ok).
- Sits on the memory side of the pipeline's M-stage data port. It accepts one request at a time, services it from an internal word-organised memory, and returns read data after a programmable latency.
- Used as the bench/SoC data memory, so the core is exercised against address-phase stalls and multi-cycle data latency.

---
 rtl/sram_like_resp.sv | 162 ++++++++++++++++
 tb/tb_sram_like_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// sram_like_resp: responder end of an sram-like req/addr_ok/data_ok handshake.
// One request at a time, served from an internal word memory. A write is
// committed on the accept edge. The response pulse arrives DATA_LAT cycles
// after the accept cycle.
module sram_like_resp #(
    parameter int AW        = 10,
    parameter int ADDR_WAIT = 0,
    parameter int DATA_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_CNT = 4'(ADDR_WAIT);
    localparam logic [3:0] LAT_M1   = 4'(DATA_LAT - 1);
    localparam logic       LAT_ONE  = (DATA_LAT == 1);

    // Byte-lane enables for a request of the given size at the given offset.
    function automatic logic [3:0] lane_strobe(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    lane_strobe = 4'b0001 << off;
            2'd1:    lane_strobe = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    lane_strobe = 4'b1111;
            default: lane_strobe = 4'b0000;
        endcase
    endfunction

    // Misalignment or illegal size.
    function automatic logic align_err(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    align_err = 1'b0;
            2'd1:    align_err = off[0];
            2'd2:    align_err = (off != 2'd0);
            default: align_err = 1'b1;
        endcase
    endfunction

    logic [1:0]    state_r;
    logic [3:0]    acnt_r;
    logic [3:0]    dcnt_r;
    logic          lat_wr_r;
    logic          lat_err_r;
    logic [AW-1:0] lat_idx_r;
    logic [31:0]   mem_r [0:(1<<AW)-1];

    logic [AW-1:0] idx_s;
    logic [3:0]    strobe_s;
    logic          err_s;
    logic          accept_s;
    logic          wait_met_s;
    logic          unused_s;

    // Decode the incoming request and form the address-phase handshake.
    always_comb begin
        idx_s      = addr[AW+1:2];
        strobe_s   = lane_strobe(size, addr[1:0]);
        err_s      = align_err(size, addr[1:0]);
        // acnt+1 > WAIT is the same as acnt >= WAIT, without a constant compare at WAIT=0.
        wait_met_s = ({1'b0, acnt_r} + 5'd1) > {1'b0, WAIT_CNT};
        if (state_r == ST_IDLE) begin
            addr_ok = req & wait_met_s;
        end else begin
            addr_ok = 1'b0;
        end
        accept_s   = addr_ok;
        unused_s   = ^addr[31:AW+2];
    end

    // Commit write lanes on the accept edge. Memory is never reset.
    always_ff @(posedge clk) begin
        if (accept_s && wr && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Handshake state machine, address-wait and data-latency counters, response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            acnt_r    <= 4'd0;
            dcnt_r    <= 4'd0;
            lat_wr_r  <= 1'b0;
            lat_err_r <= 1'b0;
            lat_idx_r <= '0;
            data_ok   <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acnt_r    <= 4'd0;
                        dcnt_r    <= LAT_M1;
                        lat_wr_r  <= wr;
                        lat_err_r <= err_s;
                        lat_idx_r <= idx_s;
                        // A one-cycle latency responds straight from the accept edge.
                        if (LAT_ONE) begin
                            state_r <= ST_RESP;
                            data_ok <= 1'b1;
                            err     <= err_s;
                            if (!wr) begin
                                rdata <= mem_r[idx_s];
                            end
                        end else begin
                            state_r <= ST_BUSY;
                        end
                    end else if (req) begin
                        acnt_r <= (acnt_r == 4'd15) ? acnt_r : acnt_r + 4'd1;
                    end else begin
                        acnt_r <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    // The response is registered when the last waiting cycle ends.
                    if (dcnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                        dcnt_r  <= 4'd0;
                        data_ok <= 1'b1;
                        err     <= lat_err_r;
                        if (!lat_wr_r) begin
                            rdata <= mem_r[lat_idx_r];
                        end
                    end else begin
                        dcnt_r <= dcnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    acnt_r  <= 4'd0;
                    data_ok <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    acnt_r  <= 4'd0;
                    dcnt_r  <= 4'd0;
                    data_ok <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: fixed vector table, randomized traffic against a
// byte-level memory model, and hand sequences for wait/latency/reset corners.
module tb_sram_like_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, wr0, req1, wr1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        addr_ok0, data_ok0, err0, addr_ok1, data_ok1, err1;
    logic [31:0] rdata0, rdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_resp u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .wr(wr0), .size(size0), .addr(addr0),
        .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0), .err(err0)
    );

    sram_like_resp #(.AW(10), .ADDR_WAIT(3), .DATA_LAT(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
        .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1), .err(err1)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [15];
    logic [7:0]  mb [4096];
    logic [31:0] last0, last1, rd, exp_rd;
    logic        e, exp_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input int s, input logic r, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        if (s == 1) begin
            req1 = r; wr1 = w; size1 = sz; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; wr0 = w; size0 = sz; addr0 = a; wdata0 = d;
        end
    endtask

    function automatic logic aok(input int s);
        return (s == 1) ? addr_ok1 : addr_ok0;
    endfunction

    function automatic logic dok(input int s);
        return (s == 1) ? data_ok1 : data_ok0;
    endfunction

    // Model: a request of 2^size bytes must be naturally aligned; size 3 is illegal.
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n;
        n = 32'd1 << sz;
        return (sz == 2'd3) || ((a % n) != 0);
    endfunction

    task automatic model_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned n, ba;
        n = 32'd1 << sz;
        for (int k = 0; k < n; k++) begin
            ba = (a + k) % 4096;
            mb[ba] = d[8*(ba % 4) +: 8];
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned base;
        base = (a % 4096) & 32'hFFC;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    // One complete transaction; checks address wait, data latency and the pulse width.
    task automatic txn(input int s, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int exp_wait, input int exp_lat,
                       output logic [31:0] rdo, output logic eo);
        int n;
        bit got;
        @(posedge clk); #1;
        set_in(s, 1'b1, w, sz, a, d);
        got = 1'b0; n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (aok(s)) got = 1'b1;
            else n++;
        end
        chk("addr_wait", 32'(n), 32'(exp_wait));
        @(posedge clk); #1;
        set_in(s, 1'b0, w, sz, a, d);
        got = 1'b0; n = 0; rdo = 32'd0; eo = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (dok(s)) begin
                got = 1'b1;
                rdo = (s == 1) ? rdata1 : rdata0;
                eo  = (s == 1) ? err1 : err0;
            end
        end
        chk("data_lat", 32'(n), 32'(exp_lat));
        @(negedge clk);
        chk("pulse_end", {31'd0, dok(s)}, 32'd0);
    endtask

    initial begin
        int  pulses;
        bit  got;
        logic w;
        logic [1:0] sz;
        logic [31:0] a, d;

        tbl[0]  = '{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 32'h10,   32'h11223344, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 2'd0, 32'h12,   32'h00AA0000, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h11AA3344, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 32'h12,   32'hBEEF0000, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hBEEF3344, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 32'h13,   32'h12340000, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hBEEF3344, 1'b0};
        tbl[9]  = '{1'b0, 2'd3, 32'h10,   32'h0,        32'hBEEF3344, 1'b1};
        tbl[10] = '{1'b1, 2'd3, 32'h10,   32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 2'd2, 32'h1010, 32'h0,        32'hBEEF3344, 1'b0};
        tbl[12] = '{1'b1, 2'd2, 32'h1010, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 2'd0, 32'h11,   32'h0,        32'hCAFEF00D, 1'b0};
        tbl[14] = '{1'b0, 2'd2, 32'h12,   32'h0,        32'hCAFEF00D, 1'b1};

        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        set_in(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok0", {31'd0, addr_ok0}, 32'd0);
        chk("rst_data_ok0", {31'd0, data_ok0}, 32'd0);
        chk("rst_err0",     {31'd0, err0},     32'd0);
        chk("rst_rdata0",   rdata0,            32'd0);
        chk("rst_rdata1",   rdata1,            32'd0);
        rst = 1'b1;

        // Fixed vectors on the zero-wait, one-cycle-latency instance.
        last0 = 32'd0;
        for (int i = 0; i < 15; i++) begin
            txn(0, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, 0, 1, rd, e);
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
            if (tbl[i].wr) begin
                chk($sformatf("tbl%0d_hold", i), rd, last0);
            end else begin
                chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
                last0 = rd;
            end
        end

        // Prefill words 0..7 so the model knows every word random traffic touches.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            txn(0, 1'b1, 2'd2, 32'(i * 4), d, 0, 1, rd, e);
            model_write(2'd2, 32'(i * 4), d);
        end

        // Random traffic, with random upper address bits exercising aliasing.
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
            d  = $urandom;
            exp_e  = model_err(sz, a);
            exp_rd = w ? last0 : model_word(a);
            txn(0, w, sz, a, d, 0, 1, rd, e);
            chk("rnd_err", {31'd0, e}, {31'd0, exp_e});
            chk("rnd_rdata", rd, exp_rd);
            if (!w) last0 = rd;
            if (w && !exp_e) model_write(sz, a, d);
        end

        // ADDR_WAIT=3, DATA_LAT=4 with req held: addr_ok at 3 and 11, data_ok at 7 and 15.
        @(posedge clk); #1;
        set_in(1, 1'b1, 1'b1, 2'd2, 32'h20, 32'h0BADF00D);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("held_aok_c%0d", c), {31'd0, addr_ok1}, {31'd0, (c == 3 || c == 11)});
            chk($sformatf("held_dok_c%0d", c), {31'd0, data_ok1}, {31'd0, (c == 7 || c == 15)});
        end
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 2'd2, 32'h20, 32'd0);
        repeat (2) @(negedge clk);

        // req drops for one cycle before accept: the wait restarts.
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            set_in(1, ((c < 2) || (c >= 3 && c <= 6)), 1'b0, 2'd2, 32'h20, 32'd0);
            @(negedge clk);
            chk($sformatf("drop_aok_c%0d", c), {31'd0, addr_ok1}, {31'd0, (c == 6)});
            chk($sformatf("drop_dok_c%0d", c), {31'd0, data_ok1}, {31'd0, (c == 10)});
            if (c == 10) chk("drop_rdata", rdata1, 32'h0BADF00D);
        end

        // Reset while a read is in BUSY: no response, rdata clears at once, memory survives.
        txn(1, 1'b0, 2'd2, 32'h20, 32'd0, 3, 4, rd, e);
        chk("pre_rst_rdata", rd, 32'h0BADF00D);
        @(posedge clk); #1;
        set_in(1, 1'b1, 1'b0, 2'd2, 32'h1020, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (addr_ok1) got = 1'b1;
        end
        chk("busy_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 2'd2, 32'h1020, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rdata1", rdata1, 32'd0);
        chk("async_rdata0", rdata0, 32'd0);
        chk("async_dok1", {31'd0, data_ok1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (data_ok1) pulses++;
        end
        chk("no_resp_after_rst", 32'(pulses), 32'd0);
        txn(1, 1'b0, 2'd2, 32'h1020, 32'd0, 3, 4, rd, e);
        chk("alias_retained1", rd, 32'h0BADF00D);
        chk("alias_err1", {31'd0, e}, 32'd0);
        txn(0, 1'b0, 2'd2, 32'h10 + 32'h1000, 32'd0, 0, 1, rd, e);
        chk("alias_retained0", rd, model_word(32'h10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
